// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions.
// Contents:
//   fetch_state_t        - fetch controller states (BOOT, RUN, HALTED_BY_STALL)
//   DEFAULT_RESET_VECTOR - PC value loaded at reset
//   DEFAULT_PC_STEP      - byte increment per sequential fetch
//   NOP_INSTR            - canonical NOP (addi x0,x0,0), handy for benches
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT            = 2'd0,
        RUN             = 2'd1,
        HALTED_BY_STALL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP      = 4;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

endpackage

// File: rtl/pc_register.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   advance    - step the PC by PC_STEP (one sequential fetch)
//   load       - load a redirect target; takes priority over advance
//   load_pc    - redirect target, forced to word alignment on load
//   pc         - current PC
module pc_register
    import cpu_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                       PC_STEP       = DEFAULT_PC_STEP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     advance,
    input  logic                     load,
    input  logic [ADDRESS_WIDTH-1:0] load_pc,
    output logic [ADDRESS_WIDTH-1:0] pc
);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;

    // Redirect targets drop their two low bits; the increment simply wraps
    // modulo 2^ADDRESS_WIDTH.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc & ~ADDRESS_WIDTH'(3);
        end else if (advance) begin
            pc_d = pc_q + ADDRESS_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational instruction memory
// read port and presents the fetched instruction to decode through a
// registered valid/ready output slot.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   imem_address        - memory address (the PC itself)
//   imem_instruction    - memory read data, same cycle as the address
//   stall               - freeze fetch; a held slot may still drain
//   redirect_valid/_pc  - change the PC; squashes the output slot
//   if_valid/if_ready   - output slot handshake with decode
//   if_pc/if_instruction- slot contents
//   misaligned_redirect - pulse when a redirect target was not word aligned
//   fetch_count         - slots accepted by decode, saturating
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                       PC_STEP       = DEFAULT_PC_STEP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0]    imem_instruction,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0]    if_instruction,
    output logic                     misaligned_redirect,
    output logic [31:0]              fetch_count
);

    fetch_state_t             state_q;
    logic                     if_valid_q;
    logic [ADDRESS_WIDTH-1:0] if_pc_q;
    logic [DATA_WIDTH-1:0]    if_instruction_q;
    logic                     misaligned_q;
    logic [31:0]              fetch_count_q;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     accept;
    logic                     fire;

    // A fetch fills the slot only when it is empty or being drained this
    // cycle, so a stalled-by-decode slot is never overwritten.
    assign accept = if_valid_q & if_ready;
    assign fire   = (state_q == RUN) & ~stall & ~redirect_valid & (~if_valid_q | if_ready);

    pc_register #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_VECTOR  (RESET_VECTOR),
        .PC_STEP       (PC_STEP)
    ) u_pc_register (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (fire),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // Controller, output slot and debug counter. Redirect dominates the slot
    // update: it squashes whatever is there and is never counted, even when
    // decode happens to be ready in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= BOOT;
            if_valid_q       <= 1'b0;
            if_pc_q          <= '0;
            if_instruction_q <= '0;
            misaligned_q     <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            misaligned_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);

            unique case (state_q)
                BOOT:            state_q <= RUN;
                RUN:             if (stall && !redirect_valid) state_q <= HALTED_BY_STALL;
                HALTED_BY_STALL: if (!stall || redirect_valid) state_q <= RUN;
                default:         state_q <= BOOT;
            endcase

            if (redirect_valid) begin
                if_valid_q <= 1'b0;
            end else if (fire) begin
                if_valid_q       <= 1'b1;
                if_pc_q          <= pc;
                if_instruction_q <= imem_instruction;
            end else if (accept) begin
                if_valid_q <= 1'b0;
            end

            if (accept && !redirect_valid && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    assign imem_address        = pc;
    assign if_valid            = if_valid_q;
    assign if_pc               = if_pc_q;
    assign if_instruction      = if_instruction_q;
    assign misaligned_redirect = misaligned_q;
    assign fetch_count         = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with fixed expectations,
// then randomized traffic against a cycle-level behavioural model.
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        ifValid;
    logic        ifReady;
    logic [31:0] ifPc;
    logic [31:0] ifInstruction;
    logic        misalignedRedirect;
    logic [31:0] fetchCount;

    int checks;
    int failures;

    // Behavioural model state: 0 = BOOT, 1 = RUN, 2 = halted by stall
    logic [31:0] mPc, mIfPc, mInstr, mCnt;
    logic        mValid, mMis;
    int          mState;

    instruction_fetch dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .imem_address        (imem_address),
        .imem_instruction    (imem_instruction),
        .stall               (stall),
        .redirect_valid      (redirectValid),
        .redirect_pc         (redirectPc),
        .if_valid            (ifValid),
        .if_ready            (ifReady),
        .if_pc               (ifPc),
        .if_instruction      (ifInstruction),
        .misaligned_redirect (misalignedRedirect),
        .fetch_count         (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded instruction memory: two fixed words, pseudo-random elsewhere
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return NOP_INSTR;
        if (a == 32'h4) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_instruction = memWord(imem_address);

    function automatic void modelReset();
        mPc = 32'h0; mIfPc = 32'h0; mInstr = 32'h0; mCnt = 32'h0;
        mValid = 1'b0; mMis = 1'b0; mState = 0;
    endfunction

    // One clock of the fetch rules, evaluated from the inputs held across the edge
    function automatic void modelUpdate();
        bit doFetch, taken;
        doFetch = (mState == 1) && !stall && !redirectValid && (!mValid || ifReady);
        taken   = mValid && ifReady;
        if (taken && !redirectValid && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
        mMis = redirectValid && (redirectPc % 4 != 0);
        if (redirectValid) begin
            mPc = redirectPc - (redirectPc % 4);
            mValid = 1'b0;
        end else if (doFetch) begin
            mIfPc = mPc; mInstr = memWord(mPc); mValid = 1'b1; mPc = mPc + 4;
        end else if (taken) begin
            mValid = 1'b0;
        end
        if (mState == 0) mState = 1;
        else if (mState == 1 && stall && !redirectValid) mState = 2;
        else if (mState == 2 && (!stall || redirectValid)) mState = 1;
    endfunction

    task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc, input bit rdy);
        stall = st; redirectValid = rv; redirectPc = rpc; ifReady = rdy;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; redirectValid = 0; redirectPc = 0; ifReady = 1;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (imem_address !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got %h want 0", imem_address); end
            checks++; if (ifValid !== 1'b0 || ifPc !== 32'h0 || ifInstruction !== 32'h0) begin failures++; $display("[TB] FAIL reset_slot got v=%b pc=%h i=%h want 0", ifValid, ifPc, ifInstruction); end
            checks++; if (fetchCount !== 32'h0 || misalignedRedirect !== 1'b0) begin failures++; $display("[TB] FAIL reset_misc got cnt=%h mis=%b want 0", fetchCount, misalignedRedirect); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        applyStimulus(0, 0, 0, 1);
        checks++; if (imem_address !== 32'h0 || ifValid !== 1'b0) begin failures++; $display("[TB] FAIL boot_cycle got addr=%h v=%b want 0/0", imem_address, ifValid); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (imem_address !== 32'h4 || ifValid !== 1'b1 || ifPc !== 32'h0 || ifInstruction !== 32'h0000_0013) begin failures++; $display("[TB] FAIL first_fetch got addr=%h v=%b pc=%h i=%h want 4/1/0/00000013", imem_address, ifValid, ifPc, ifInstruction); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (imem_address !== 32'h8 || ifPc !== 32'h4 || ifInstruction !== 32'h0010_0093 || fetchCount !== 32'd1) begin failures++; $display("[TB] FAIL second_fetch got addr=%h pc=%h i=%h cnt=%0d want 8/4/00100093/1", imem_address, ifPc, ifInstruction, fetchCount); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            checks++; if (ifValid !== 1'b1 || ifPc !== 32'h4 || ifInstruction !== 32'h0010_0093 || imem_address !== 32'h8) begin failures++; $display("[TB] FAIL backpressure_hold got v=%b pc=%h i=%h addr=%h want 1/4/00100093/8", ifValid, ifPc, ifInstruction, imem_address); end
        end
        applyStimulus(0, 0, 0, 1);
        checks++; if (ifPc !== 32'h8 || ifInstruction !== memWord(32'h8) || fetchCount !== 32'd2) begin failures++; $display("[TB] FAIL backpressure_resume got pc=%h cnt=%0d want 8/2", ifPc, fetchCount); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (fetchCount !== 32'd3 || imem_address !== 32'h10) begin failures++; $display("[TB] FAIL count_three got cnt=%0d addr=%h want 3/10", fetchCount, imem_address); end
    endtask

    task automatic test_stall();
        applyStimulus(1, 0, 0, 1);
        checks++; if (ifValid !== 1'b0 || fetchCount !== 32'd4 || imem_address !== 32'h10) begin failures++; $display("[TB] FAIL stall_drain got v=%b cnt=%0d addr=%h want 0/4/10", ifValid, fetchCount, imem_address); end
        checks++; if (dut.state_q !== HALTED_BY_STALL) begin failures++; $display("[TB] FAIL stall_state got %0d want %0d", dut.state_q, HALTED_BY_STALL); end
        applyStimulus(1, 0, 0, 1);
        checks++; if (ifValid !== 1'b0 || imem_address !== 32'h10 || fetchCount !== 32'd4) begin failures++; $display("[TB] FAIL stall_hold got v=%b addr=%h cnt=%0d want 0/10/4", ifValid, imem_address, fetchCount); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (dut.state_q !== RUN || ifValid !== 1'b0) begin failures++; $display("[TB] FAIL stall_exit got st=%0d v=%b want %0d/0", dut.state_q, ifValid, RUN); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (ifValid !== 1'b1 || ifPc !== 32'h10) begin failures++; $display("[TB] FAIL stall_restart got v=%b pc=%h want 1/10", ifValid, ifPc); end
    endtask

    task automatic test_redirect();
        applyStimulus(0, 1, 32'h40, 1);
        checks++; if (ifValid !== 1'b0 || fetchCount !== 32'd4 || imem_address !== 32'h40 || misalignedRedirect !== 1'b0) begin failures++; $display("[TB] FAIL redirect_squash got v=%b cnt=%0d addr=%h mis=%b want 0/4/40/0", ifValid, fetchCount, imem_address, misalignedRedirect); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (ifValid !== 1'b1 || ifPc !== 32'h40 || imem_address !== 32'h44) begin failures++; $display("[TB] FAIL redirect_target got v=%b pc=%h addr=%h want 1/40/44", ifValid, ifPc, imem_address); end
    endtask

    task automatic test_misaligned_wrap();
        applyStimulus(0, 1, 32'h46, 1);
        checks++; if (imem_address !== 32'h44 || misalignedRedirect !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_align got addr=%h mis=%b want 44/1", imem_address, misalignedRedirect); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (misalignedRedirect !== 1'b0 || ifPc !== 32'h44) begin failures++; $display("[TB] FAIL misaligned_pulse got mis=%b pc=%h want 0/44", misalignedRedirect, ifPc); end
        applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
        checks++; if (imem_address !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_load got %h want fffffffc", imem_address); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (imem_address !== 32'h0 || ifPc !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_increment got addr=%h pc=%h want 0/fffffffc", imem_address, ifPc); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 1, 32'h100, 1);
        applyStimulus(0, 1, 32'h203, 1);
        checks++; if (imem_address !== 32'h200 || ifValid !== 1'b0 || misalignedRedirect !== 1'b1 || fetchCount !== 32'd4) begin failures++; $display("[TB] FAIL back_to_back got addr=%h v=%b mis=%b cnt=%0d want 200/0/1/4", imem_address, ifValid, misalignedRedirect, fetchCount); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 1023);
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 2) != 0);
            checks++; if (imem_address !== mPc || ifValid !== mValid || ifPc !== mIfPc || ifInstruction !== mInstr || fetchCount !== mCnt || misalignedRedirect !== mMis) begin
                failures++;
                $display("[TB] FAIL random_cycle%0d got a=%h v=%b pc=%h i=%h c=%0d m=%b want a=%h v=%b pc=%h i=%h c=%0d m=%b", i, imem_address, ifValid, ifPc, ifInstruction, fetchCount, misalignedRedirect, mPc, mValid, mIfPc, mInstr, mCnt, mMis);
            end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checks++; if (ifValid !== 1'b1) begin failures++; $display("[TB] FAIL async_setup got v=%b want 1", ifValid); end
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checks++; if (ifValid !== 1'b0 || imem_address !== 32'h0 || fetchCount !== 32'h0 || ifPc !== 32'h0) begin failures++; $display("[TB] FAIL async_reset got v=%b addr=%h cnt=%0d pc=%h want 0/0/0/0", ifValid, imem_address, fetchCount, ifPc); end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1);
        checks++; if (ifValid !== 1'b0 || imem_address !== 32'h0) begin failures++; $display("[TB] FAIL post_reset_boot got v=%b addr=%h want 0/0", ifValid, imem_address); end
        applyStimulus(0, 0, 0, 1);
        checks++; if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInstruction !== NOP_INSTR) begin failures++; $display("[TB] FAIL post_reset_fetch got v=%b pc=%h i=%h want 1/0/00000013", ifValid, ifPc, ifInstruction); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_stall();
        test_redirect();
        test_misaligned_wrap();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
